dup_check_alu: RTL and testbench

- Parametrised, pipelined self-checking ALU for the dependable-computing datapath.
- Takes parity-protected operands A, B and a one-hot op select C, and computes the result on two independent channels, X and Y.
- Flags input-code errors on two-rail XE and channel disagreement on two-rail YE.
- Tracks fault history in a NORMAL/DEGRADED/FAILED state machine with an error counter.

---
 rtl/dup_check_alu.sv | 207 ++++++++++++++++++++
 tb/tb_dup_check_alu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dup_check_alu.sv
// rtl/dup_check_alu.sv - two-stage duplicated ALU with input-code check, X/Y compare and fault-state tracking
// Optional FAULT_INJ_EN adds input inj, which flips bit 0 of channel Y on load.
module dup_check_alu #(
   parameter int WIDTH      = 3,
   parameter int ERR_THRESH = 3,
   parameter int CLEAN_RUN  = 4,
   parameter int CNT_W      = 4
) (
   input  logic             clk_50,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             par,
   input  logic [2:0]       c,
   input  logic             clr_fault,
`ifdef FAULT_INJ_EN
   input  logic             inj,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] x,
   output logic             xc,
   output logic [1:0]       xe,
   output logic [WIDTH-1:0] y,
   output logic             yc,
   output logic [1:0]       ye,
   output logic [1:0]       fault_state,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int RUN_W = $clog2(CLEAN_RUN + 1);
   localparam logic [CNT_W-1:0] L_THRESH = CNT_W'(ERR_THRESH);
   localparam logic [CNT_W-1:0] L_CNT_MAX = '1;
   localparam logic [RUN_W-1:0] L_RUN = RUN_W'(CLEAN_RUN);

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'b00,
      ST_DEGRADED = 2'b01,
      ST_FAILED   = 2'b10
   } state_t;

   state_t           r_state, w_next_state;
   logic [CNT_W-1:0] r_err_cnt, w_next_cnt, w_cnt_inc;
   logic [RUN_W-1:0] r_run, w_next_run;

   logic             r1_valid, r1_perr, r1_oherr;
   logic [WIDTH-1:0] r1_a, r1_b;
   logic [2:0]       r1_c;

   logic [WIDTH-1:0] w_x_res, w_y_sum, w_y_res, w_y_final;
   logic             w_x_c, w_y_c, w_y_carry, w_ierr, w_evt, w_clean;

   // Stage 1: operand capture and input-code checks; FAILED blocks new work.
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_a     <= '0;
         r1_b     <= '0;
         r1_c     <= '0;
         r1_perr  <= 1'b0;
         r1_oherr <= 1'b0;
      end else begin
         r1_valid <= in_valid && (r_state != ST_FAILED);
         if (in_valid) begin
            r1_a     <= a;
            r1_b     <= b;
            r1_c     <= c;
            r1_perr  <= ^{a, b, par};
            r1_oherr <= !((c == 3'b001) || (c == 3'b010) || (c == 3'b100));
         end
      end
   end

   always_comb begin
      w_x_res = '0;
      w_x_c   = 1'b0;
      case (r1_c)
         3'b001:  {w_x_c, w_x_res} = {1'b0, r1_a} + {1'b0, r1_b};
         3'b010:  w_x_res = r1_a & r1_b;
         3'b100:  w_x_res = r1_a ^ r1_b;
         default: w_x_res = '0;
      endcase
   end

   // Channel Y uses a ripple-carry and De Morgan forms so it shares no gates with X.
   always_comb begin
      w_y_sum   = '0;
      w_y_carry = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         w_y_sum[i] = r1_a[i] ^ r1_b[i] ^ w_y_carry;
         w_y_carry  = (r1_a[i] & r1_b[i]) | (w_y_carry & (r1_a[i] ^ r1_b[i]));
      end
      w_y_res = '0;
      w_y_c   = 1'b0;
      if (r1_c[0]) begin
         w_y_res = w_y_sum;
         w_y_c   = w_y_carry;
      end else if (r1_c[1]) begin
         w_y_res = ~(~r1_a | ~r1_b);
      end else if (r1_c[2]) begin
         w_y_res = (r1_a | r1_b) & ~(r1_a & r1_b);
      end
   end

`ifdef FAULT_INJ_EN
   assign w_y_final = w_y_res ^ {{(WIDTH-1){1'b0}}, inj};
`else
   assign w_y_final = w_y_res;
`endif

   assign w_ierr = r1_perr | r1_oherr;

   // Stage 2: result registers; x/y/carries hold while no data is present.
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         x  <= '0;
         y  <= '0;
         xc <= 1'b0;
         yc <= 1'b0;
         xe <= 2'b00;
         ye <= 2'b00;
      end else if (r1_valid) begin
         out_valid <= 1'b1;
         if (w_ierr) begin
            x  <= '0;
            y  <= '0;
            xc <= 1'b0;
            yc <= 1'b0;
            xe <= 2'b11;
            ye <= 2'b01;
         end else begin
            x  <= w_x_res;
            y  <= w_y_final;
            xc <= w_x_c;
            yc <= w_y_c;
            xe <= 2'b01;
            ye <= ({w_x_res, w_x_c} == {w_y_final, w_y_c}) ? 2'b01 : 2'b11;
         end
      end else begin
         out_valid <= 1'b0;
         xe <= 2'b00;
         ye <= 2'b00;
      end
   end

   assign w_evt     = out_valid && ((xe == 2'b11) || (ye == 2'b11));
   assign w_clean   = out_valid && !w_evt;
   assign w_cnt_inc = (r_err_cnt == L_CNT_MAX) ? r_err_cnt : r_err_cnt + 1'b1;

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         r_state   <= ST_NORMAL;
         r_err_cnt <= '0;
         r_run     <= '0;
      end else begin
         r_state   <= w_next_state;
         r_err_cnt <= w_next_cnt;
         r_run     <= w_next_run;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_err_cnt;
      w_next_run   = r_run;
      if (clr_fault) begin
         // Clear wins first; a coincident event is then counted unless we were FAILED.
         w_next_state = ST_NORMAL;
         w_next_cnt   = '0;
         w_next_run   = '0;
         if (w_evt && (r_state != ST_FAILED)) begin
            w_next_state = ST_DEGRADED;
            w_next_cnt   = CNT_W'(1);
         end
      end else begin
         case (r_state)
            ST_NORMAL: begin
               if (w_evt) begin
                  w_next_state = ST_DEGRADED;
                  w_next_cnt   = w_cnt_inc;
                  w_next_run   = '0;
               end
            end
            ST_DEGRADED: begin
               if (w_evt) begin
                  w_next_cnt = w_cnt_inc;
                  w_next_run = '0;
                  if (w_cnt_inc >= L_THRESH) w_next_state = ST_FAILED;
               end else if (w_clean) begin
                  if (r_run + 1'b1 >= L_RUN) begin
                     w_next_state = ST_NORMAL;
                     w_next_run   = '0;
                  end else begin
                     w_next_run = r_run + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign fault_state = r_state;
   assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_dup_check_alu.sv
// tb/tb_dup_check_alu.sv - directed self-checking bench for dup_check_alu
// Build with +define+FAULT_INJ_EN to also exercise the injection port.
module tb_dup_check_alu;

   logic       clk_50 = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] a, b;
   logic       par;
   logic [2:0] c;
   logic       clr_fault;
   logic       inj;
   logic       out_valid;
   logic [2:0] x, y;
   logic       xc, yc;
   logic [1:0] xe, ye, fault_state;
   logic [3:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   dup_check_alu #(.WIDTH(3), .ERR_THRESH(3), .CLEAN_RUN(4), .CNT_W(4)) dut (
      .clk_50(clk_50), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .par(par), .c(c),
      .clr_fault(clr_fault),
`ifdef FAULT_INJ_EN
      .inj(inj),
`endif
      .out_valid(out_valid), .x(x), .xc(xc), .xe(xe), .y(y), .yc(yc), .ye(ye),
      .fault_state(fault_state), .err_cnt(err_cnt)
   );

   always #5 clk_50 = ~clk_50;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where the result is visible.
   task automatic run_op(input logic [2:0] ta, input logic [2:0] tb, input logic tp, input logic [2:0] tc);
      a = ta; b = tb; par = tp; c = tc; in_valid = 1'b1;
      @(negedge clk_50);
      in_valid = 1'b0;
      @(negedge clk_50);
   endtask

   task automatic pulse_clr();
      clr_fault = 1'b1;
      @(negedge clk_50);
      clr_fault = 1'b0;
   endtask

   logic [2:0] cv;
   logic       oh;

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; par = 1'b0; c = '0;
      clr_fault = 1'b0; inj = 1'b0;
      repeat (2) @(negedge clk_50);
      check("rst_out_valid", out_valid, 0);
      check("rst_x", x, 0);
      check("rst_xe", xe, 0);
      check("rst_ye", ye, 0);
      check("rst_state", fault_state, 0);
      check("rst_cnt", err_cnt, 0);
      rst = 1'b0;
      @(negedge clk_50);

      run_op(3'b011, 3'b010, 1'b1, 3'b001);
      check("add_valid", out_valid, 1);
      check("add_x", x, 3'b101);
      check("add_y", y, 3'b101);
      check("add_xc", xc, 0);
      check("add_xe", xe, 2'b01);
      check("add_ye", ye, 2'b01);
      @(negedge clk_50);
      check("idle_valid", out_valid, 0);
      check("idle_xe", xe, 2'b00);
      check("idle_x_hold", x, 3'b101);
      check("add_state", fault_state, 0);

      run_op(3'b111, 3'b001, 1'b0, 3'b001);
      check("ovf_x", x, 3'b000);
      check("ovf_y", y, 3'b000);
      check("ovf_xc", xc, 1);
      check("ovf_yc", yc, 1);
      check("ovf_ye", ye, 2'b01);

      run_op(3'b110, 3'b011, 1'b0, 3'b010);
      check("and_x", x, 3'b010);
      check("and_xc", xc, 0);
      run_op(3'b101, 3'b011, 1'b0, 3'b100);
      check("xor_x", x, 3'b110);
      check("xor_y", y, 3'b110);

      run_op(3'b011, 3'b010, 1'b0, 3'b010);
      check("perr_xe", xe, 2'b11);
      check("perr_ye", ye, 2'b01);
      check("perr_x", x, 0);
      @(negedge clk_50);
      check("perr_state", fault_state, 2'b01);
      check("perr_cnt", err_cnt, 1);
      for (int i = 0; i < 4; i++) begin
         run_op(3'b001, 3'b001, 1'b0, 3'b010);
         @(negedge clk_50);
         if (i == 2) check("run3_state", fault_state, 2'b01);
      end
      check("recover_state", fault_state, 2'b00);
      check("recover_cnt", err_cnt, 1);

      pulse_clr();
      for (int i = 0; i < 8; i++) begin
         cv = i[2:0];
         oh = (cv == 3'b001) || (cv == 3'b010) || (cv == 3'b100);
         run_op(3'b001, 3'b000, 1'b1, cv);
         check($sformatf("sweep_xe_c%0d", i), xe, oh ? 2'b01 : 2'b11);
         check($sformatf("sweep_x_c%0d", i), x, (cv == 3'b001 || cv == 3'b100) ? 3'b001 : 3'b000);
         @(negedge clk_50);
         check($sformatf("sweep_state_c%0d", i), fault_state, oh ? 2'b00 : 2'b01);
         pulse_clr();
      end

      for (int i = 0; i < 3; i++) begin
         run_op(3'b011, 3'b010, 1'b1, 3'b011);
         @(negedge clk_50);
      end
      check("failed_state", fault_state, 2'b10);
      check("failed_cnt", err_cnt, 3);
      run_op(3'b011, 3'b010, 1'b1, 3'b001);
      check("failed_no_valid", out_valid, 0);
      @(negedge clk_50);
      check("failed_sticky", fault_state, 2'b10);
      pulse_clr();
      check("clr_state", fault_state, 2'b00);
      check("clr_cnt", err_cnt, 0);

      run_op(3'b011, 3'b010, 1'b0, 3'b001);
      run_op(3'b011, 3'b010, 1'b0, 3'b001);
      @(negedge clk_50);
      check("two_err_cnt", err_cnt, 2);
      run_op(3'b011, 3'b010, 1'b0, 3'b001);
      pulse_clr();
      check("clr_evt_state", fault_state, 2'b01);
      check("clr_evt_cnt", err_cnt, 1);

`ifdef FAULT_INJ_EN
      inj = 1'b1;
      run_op(3'b110, 3'b011, 1'b0, 3'b010);
      inj = 1'b0;
      check("inj_x", x, 3'b010);
      check("inj_y", y, 3'b011);
      check("inj_ye", ye, 2'b11);
      @(negedge clk_50);
      check("inj_cnt", err_cnt, 2);
`endif

      run_op(3'b101, 3'b011, 1'b0, 3'b100);
      check("pre_rst_x", x, 3'b110);
      @(negedge clk_50);
      a = 3'b011; b = 3'b010; par = 1'b1; c = 3'b001; in_valid = 1'b1;
      @(negedge clk_50);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("arst_x", x, 0);
      check("arst_xe", xe, 0);
      check("arst_state", fault_state, 0);
      check("arst_cnt", err_cnt, 0);
      @(negedge clk_50);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_50);
         check($sformatf("arst_no_valid_%0d", i), out_valid, 0);
      end
      run_op(3'b011, 3'b010, 1'b1, 3'b001);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_x", x, 3'b101);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
